// File: rtl/mpc.sv
// Micro-program control mini-ALU: decodes an 18-bit instruction into func/A/B
// and registers a 9-bit result (bit 8 carry/borrow) with single-cycle latency.
module mpc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] instr,
  output logic [8:0]  out
);

  typedef enum logic [1:0] {
    F_ADD = 2'b00,
    F_SUB = 2'b01,
    F_AND = 2'b10,
    F_OR  = 2'b11
  } func_e;

  typedef struct packed {
    func_e      func;
    logic [7:0] a;
    logic [7:0] b;
  } instr_t;

  instr_t     dec;
  logic [8:0] r;

  assign dec = instr_t'(instr);

  // 9-bit arithmetic: the extra bit is carry on ADD and borrow on SUB.
  always_comb begin
    r = 9'd0;
    case (dec.func)
      F_ADD: r = {1'b0, dec.a} + {1'b0, dec.b};
      F_SUB: r = {1'b0, dec.a} - {1'b0, dec.b};
      F_AND: r = {1'b0, dec.a & dec.b};
      F_OR:  r = {1'b0, dec.a | dec.b};
      default: r = 9'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= 9'd0;
    else        out <= r;
  end

endmodule

// File: tb/tb_mpc.sv
// Self-checking bench for mpc: directed vectors, timing/reset checks and
// randomized instructions against an arithmetic reference model.
module tb_mpc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] instr;
  logic [8:0]  out;

  int n_chk  = 0;
  int n_fail = 0;

  mpc dut (.clk(clk), .rst_n(rst_n), .instr(instr), .out(out));

  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [17:0] i);
    int a, b, res;
    a = int'(i[15:8]);
    b = int'(i[7:0]);
    case (i[17:16])
      2'd0:    res = (a + b) % 512;
      2'd1:    res = (a - b + 512) % 512;
      2'd2:    res = a & b;
      default: res = a | b;
    endcase
    return res[8:0];
  endfunction

  task automatic check(input string tag, input logic [8:0] exp);
    n_chk++;
    assert (out === exp) else begin
      n_fail++;
      $error("FAIL %s: out=%h expected=%h", tag, out, exp);
    end
  endtask

  // Drive at negedge, sample 1 time unit after the following rising edge.
  task automatic step(input logic [17:0] i, input logic [8:0] exp, input string tag);
    @(negedge clk) instr = i;
    @(posedge clk) #1;
    check(tag, exp);
  endtask

  logic [17:0] ri;
  logic [8:0]  held;

  initial begin
    rst_n = 1'b0;
    instr = 18'($urandom);
    #1 check("reset_immediate", 9'd0);
    repeat (3) @(posedge clk);
    #1 check("reset_held", 9'd0);
    @(negedge clk) rst_n = 1'b1;
    instr = {2'b00, 8'hFF, 8'hFF};
    #1 check("post_release_pre_edge", 9'd0);

    step(18'b00_01001101_00101111, 9'd124,          "add_nocarry");
    step(18'b00_11001101_11101111, 9'd444,          "add_carry");
    step(18'b01_01001101_11101111, 9'd350,          "sub_borrow");
    step(18'b01_01001101_00101111, 9'd30,           "sub_noborrow");
    step(18'b10_01001101_00101111, 9'b0_0000_1101,  "and");
    step(18'b11_01001101_00101111, 9'b0_0110_1111,  "or");
    step({2'b00, 8'hFF, 8'hFF},    9'h1FE,          "add_ff_ff");
    step({2'b01, 8'h00, 8'hFF},    9'h101,          "sub_0_ff");
    step({2'b01, 8'h5A, 8'h5A},    9'h000,          "sub_equal");

    // instr change between edges must not disturb out
    step({2'b00, 8'h10, 8'h20}, 9'h030, "pre_midcycle");
    #2 instr = {2'b11, 8'hF0, 8'h0F};
    #1 check("midcycle_hold", 9'h030);
    @(posedge clk) #1;
    check("midcycle_next_edge", 9'h0FF);

    // asynchronous reset mid-sequence
    #2 rst_n = 1'b0;
    #1 check("async_reset_clear", 9'd0);
    @(posedge clk) #1;
    check("async_reset_hold", 9'd0);
    @(negedge clk) rst_n = 1'b1;
    instr = {2'b01, 8'h03, 8'h07};
    #1 check("async_release_pre_edge", 9'd0);
    @(posedge clk) #1;
    check("async_release_first_edge", 9'h1FC);

    // randomized back-to-back instructions
    for (int k = 0; k < 300; k++) begin
      ri = 18'($urandom);
      step(ri, model(ri), "random");
    end

    // random reset pulses with random traffic around them
    for (int k = 0; k < 10; k++) begin
      ri = 18'($urandom);
      step(ri, model(ri), "rand_pre_reset");
      #($urandom_range(1, 3)) rst_n = 1'b0;
      #1 check("rand_async_clear", 9'd0);
      ri = 18'($urandom);
      @(negedge clk) instr = ri;
      rst_n = 1'b1;
      #1 check("rand_release_hold", 9'd0);
      @(posedge clk) #1;
      check("rand_first_edge", model(ri));
    end

    held = out;
    #2 instr = ~instr;
    #1 check("final_stable", held);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
